// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, the x0 address and the
// registered write bundle driven onto the register-file write port.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] X0_ADDR = 5'd0;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_arbiter_chk.sv
// Protocol checks on the requester side of the writeback arbiter.
module rf_wb_arbiter_chk #(
  parameter int NUM_REQ = 3
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready
);

  // a requester left waiting must keep its request raised
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end

  a_single_grant: assert property (@(posedge clk) $onehot0(req_ready));
  a_no_spurious:  assert property (@(posedge clk) (req_ready & ~req_valid) == '0);

endmodule

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching circularly upward from ptr, at most one grant.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any_gnt
);

  function automatic int wrap_idx(input int v);
    return (v >= N) ? (v - N) : v;
  endfunction

  // circular priority search starting at ptr
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int off = 0; off < N; off++) begin
      int  idx;
      logic take;
      idx          = wrap_idx(int'(ptr) + off);
      take         = enable && !any_gnt && req[idx];
      gnt[idx]     = gnt[idx] | take;
      gnt_idx      = take ? PW'(idx) : gnt_idx;
      any_gnt      = any_gnt | take;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the single register-file write port among NUM_REQ
// writeback requesters, with a registered write stage and contention counter.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int REG_AW  = rf_pkg::REG_AW,
  parameter int CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][REG_AW-1:0] req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wb_stall,
  output logic                           rf_en,
  output logic [REG_AW-1:0]              rf_rd,
  output logic [XLEN-1:0]                rf_wdata,
  output logic [CNT_W-1:0]               contention_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;
  logic               arb_en;
  logic               contend;
  rf_wr_t             wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // reset and stall both block every grant, so ready is never raised then
  assign arb_en  = !rst && !wb_stall;
  assign contend = !wb_stall && ($countones(req_valid) >= 32'sd2);

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign req_ready = gnt;

  // next pointer, write bundle and saturating counter
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    wr_d.en  = 1'b0;
    cnt_d    = cnt_q;
    if (any_gnt) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + PW'(1);
      end
      // x0 writes complete the handshake but never reach the file
      wr_d.en   = (req_rd[gnt_idx] != X0_ADDR);
      wr_d.rd   = req_rd[gnt_idx];
      wr_d.data = req_wdata[gnt_idx];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (contend && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_en          = wr_q.en;
  assign rf_rd          = wr_q.rd;
  assign rf_wdata       = wr_q.data;
  assign contention_cnt = cnt_q;

  rf_wb_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then random traffic,
// with a second instance using a 4-bit counter to observe saturation.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;

  logic                       clk;
  logic                       rst;
  logic                       wb_stall;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][4:0]       req_rd;
  logic [NREQ-1:0][31:0]      req_wdata;
  logic [NREQ-1:0]            req_ready;
  logic                       rf_en;
  logic [4:0]                 rf_rd;
  logic [31:0]                rf_wdata;
  logic [31:0]                contention_cnt;
  logic [NREQ-1:0]            req_ready4;
  logic                       rf_en4;
  logic [4:0]                 rf_rd4;
  logic [31:0]                rf_wdata4;
  logic [3:0]                 contention_cnt4;

  rf_wb_arbiter #(.NUM_REQ(NREQ), .XLEN(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_wdata(req_wdata), .req_ready(req_ready), .wb_stall(wb_stall),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .contention_cnt(contention_cnt)
  );

  rf_wb_arbiter #(.NUM_REQ(NREQ), .XLEN(32), .REG_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_wdata(req_wdata), .req_ready(req_ready4), .wb_stall(wb_stall),
    .rf_en(rf_en4), .rf_rd(rf_rd4), .rf_wdata(rf_wdata4),
    .contention_cnt(contention_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          chk_out;
    logic [2:0]  ready;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // requester side: outstanding request per requester
  bit          pend[NREQ];
  logic [4:0]  p_rd[NREQ];
  logic [31:0] p_wd[NREQ];

  // reference model state
  int          m_ptr   = 0;
  logic        m_en    = 1'b0;
  logic [4:0]  m_rd    = 5'd0;
  logic [31:0] m_wd    = 32'd0;
  int          m_total = 0;
  bit          m_known = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic arm(input int i, input bit allow_x0);
    pend[i] = 1'b1;
    if (allow_x0 && ($urandom_range(0, 3) == 0)) p_rd[i] = 5'd0;
    else p_rd[i] = 5'($urandom_range(1, 31));
    p_wd[i] = $urandom;
  endtask

  // one clock of stimulus: drive, predict, push expectation, advance model
  task automatic step(input bit r, input bit st);
    exp_t e;
    int   g;
    int   nv;
    @(posedge clk);
    #1;
    rst      = r;
    wb_stall = st;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pend[i];
      req_rd[i]    = p_rd[i];
      req_wdata[i] = p_wd[i];
    end
    g = -1;
    if (!r && !st) begin
      for (int j = 0; j < NREQ; j++) begin
        if (g < 0 && pend[(m_ptr + j) % NREQ]) g = (m_ptr + j) % NREQ;
      end
    end
    e.chk_out = m_known;
    e.ready   = (g >= 0) ? (3'b001 << g) : 3'b000;
    e.en      = m_en;
    e.rd      = m_rd;
    e.wd      = m_wd;
    e.cnt     = 32'(m_total);
    e.cnt4    = (m_total > 15) ? 4'd15 : 4'(m_total);
    sbq.push_back(e);
    if (r) begin
      m_ptr = 0; m_en = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_total = 0; m_known = 1'b1;
    end else begin
      nv = 0;
      for (int i = 0; i < NREQ; i++) nv += int'(pend[i]);
      if (!st && nv >= 2) m_total++;
      if (g >= 0) begin
        m_en    = (p_rd[g] != 5'd0);
        m_rd    = p_rd[g];
        m_wd    = p_wd[g];
        m_ptr   = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
    end
  endtask

  // reset for two cycles; requests withdrawn only while reset is held
  task automatic do_reset();
    step(1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(1'b1, 1'b0);
  endtask

  // monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("req_ready_cnt4_inst", 32'(req_ready4), 32'(e.ready));
      if (e.chk_out) begin
        chk("rf_en", 32'(rf_en), 32'(e.en));
        chk("rf_rd", 32'(rf_rd), 32'(e.rd));
        chk("rf_wdata", rf_wdata, e.wd);
        chk("contention_cnt", contention_cnt, e.cnt);
        chk("contention_cnt_sat4", 32'(contention_cnt4), 32'(e.cnt4));
      end
    end
  end

  initial begin
    rst = 1'b1; wb_stall = 1'b0;
    req_valid = '0; req_rd = '0; req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_rd[i] = 5'd0; p_wd[i] = 32'd0;
    end

    // reset with all requesters pending: no grants
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; p_rd[i] = 5'(i + 1); p_wd[i] = 32'hA000_0000 + 32'(i);
    end
    repeat (3) step(1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(1'b1, 1'b0);

    // single requester
    pend[1] = 1'b1; p_rd[1] = 5'd5; p_wd[1] = 32'hDEAD_BEEF;
    step(1'b0, 1'b0);
    // x0 write from requester 0 (pointer wraps from 2)
    pend[0] = 1'b1; p_rd[0] = 5'd0; p_wd[0] = 32'h0000_1234;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // full contention from pointer 0
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) arm(i, 1'b0);
      step(1'b0, 1'b0);
    end

    // stall with 101 pending, then release
    do_reset();
    arm(0, 1'b0); arm(2, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // saturation of the 4-bit counter
    do_reset();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) arm(i, 1'b0);
      step(1'b0, 1'b0);
    end

    // random traffic with occasional stall and reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i] && ($urandom_range(0, 1) == 1)) arm(i, 1'b1);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0));
    end
    step(1'b0, 1'b0);

    // drain: bounded wait for the monitor to consume every expectation
    for (int t = 0; t < 4 && sbq.size() > 0; t++) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
